ahb_sram_slave: RTL

AHB-lite slave that sits directly downstream of the bus controller. It occupies one slot of the device select and mux arrays and returns rdata, ready and resp through that slot. It provides word-addressed on-chip SRAM with byte, halfword and word access. Wait states are configurable, and it gives the two-cycle ERROR response for illegal accesses.

---
 rtl/ahb_sram_slave.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave: word-addressed on-chip RAM with byte/half/word
// access, configurable wait states and a two-cycle ERROR response.
// Ports: clk, rst (async, active-low); address phase sel/write/addr/
// size/trans qualified by ready_in; wdata in the data phase; returns
// rdata, ready_out and resp (0 = OKAY, 1 = ERROR).
module ahb_sram_slave #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic [1:0]  trans,
   input  logic        ready_in,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready_out,
   output logic        resp
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0] WS_M1 =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DONE,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [3:0]      r_cnt;
   logic [3:0]      w_cnt_next;
   logic            r_write;
   logic [1:0]      r_size;
   logic [1:0]      r_lane;
   logic [AW-1:0]   r_idx;
   logic [31:0]     r_rdata;
   logic [31:0]     r_mem [DEPTH_WORDS];

   logic [31:0]     w_off;
   logic            w_active;
   logic            w_open;
   logic            w_accept;
   logic            w_oor;
   logic            w_misal;
   logic            w_badsz;
   logic            w_legal;
   logic            w_rd_done;
   logic [3:0]      w_be;

   // Unsigned wrap makes addresses below BASE_ADDR land out of range.
   assign w_off    = addr - BASE_ADDR;
   assign w_active = (trans == 2'b10) || (trans == 2'b11);
   assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE) ||
                     (r_state == S_ERR2);
   assign w_accept = w_open && sel && ready_in && w_active;
   assign w_oor    = {1'b0, w_off} >= SPAN;
   assign w_misal  = ((size == 2'b01) && addr[0]) ||
                     ((size == 2'b10) && (addr[1:0] != 2'b00));
   assign w_badsz  = (size == 2'b11);
   assign w_legal  = !(w_oor || w_misal || w_badsz);

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      ready_out  = 1'b1;
      resp       = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE, S_ERR2: begin
            if (r_state == S_ERR2) resp = 1'b1;
            if (!w_accept) begin
               w_next = S_IDLE;
            end else if (!w_legal) begin
               w_next = S_ERR1;
            end else if (WAIT_STATES > 0) begin
               w_next     = S_WAIT;
               w_cnt_next = WS_M1;
            end else begin
               w_next = S_DONE;
            end
         end
         S_WAIT: begin
            ready_out = 1'b0;
            if (r_cnt == 4'd0) w_next = S_DONE;
            else w_cnt_next = r_cnt - 4'd1;
         end
         S_ERR1: begin
            ready_out = 1'b0;
            resp      = 1'b1;
            w_next    = S_ERR2;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_write <= 1'b0;
         r_size  <= 2'b00;
         r_lane  <= 2'b00;
         r_idx   <= '0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_write <= write;
            r_size  <= size;
            r_lane  <= addr[1:0];
            r_idx   <= w_off[AW+1:2];
         end
         if (w_rd_done) r_rdata <= r_mem[r_idx];
      end
   end

   // Writes commit at the end of DONE, so a read whose data phase
   // follows sees the new word through the asynchronous read path.
   assign w_rd_done = (r_state == S_DONE) && !r_write;
   assign rdata     = w_rd_done ? r_mem[r_idx] : r_rdata;

   always_comb begin
      w_be = 4'b0000;
      unique case (r_size)
         2'b00:   w_be = 4'b0001 << r_lane;
         2'b01:   w_be = r_lane[1] ? 4'b1100 : 4'b0011;
         2'b10:   w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   // RAM is not reset; the rst term keeps an aborted write out.
   always_ff @(posedge clk) begin
      if (rst && (r_state == S_DONE) && r_write) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[r_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule
